iob_regfile_2p_loader: RTL and testbench
========================================

# iob_regfile_2p_loader

Burst write initiator for the two-port register file. Accepts a start command (base register index, register count) and a valid/ready stream of W-bit values, and turns each accepted value into one single-register write request (write address, one-hot byte strobe, lane-placed data) on the file's write port. Sits between a DMA/config sequencer and the register file; the parent concatenates the read address above `req_o`.

## Interface
- `N`, 16, number of registers in the target file
- `W`, 8, register width; must be 1..8 (one byte lane per register)
- `WDATA_W`, 32, write data width of the file
- `WADDR_W`, 4, write address width; ≥ $clog2(N)
- `WSTRB_W`, WDATA_W/8, strobe width; power of two
- `CNT_W`, $clog2(N)+1, width of burst length
- `clk_i` in 1 clock, all logic on rising edge
- `rst_n_i` in 1 reset, synchronous, active-low
- `cke_i` in 1 clock enable; low freezes all state
- `start_i` in 1 start burst (sampled only in IDLE)
- `base_i` in WADDR_W first register index
- `len_i` in CNT_W number of registers to write
- `s_valid_i` in 1 stream value valid
- `s_data_i` in W stream value
- `s_ready_o` out 1 stream ready
- `wen_o` out 1 write enable to file
- `req_o` out WADDR_W+WSTRB_W+WDATA_W {waddr, wstrb, wdata}
- `busy_o` out 1 burst in progress
- `done_o` out 1 one-cycle completion pulse
- `err_o` out 1 range error, sticky until next start

## Operation
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE, LOAD, FLUSH.
- IDLE + `start_i`: latch `base_i`, `len_i`. If len=0 → done pulse next cycle, no writes. If base+len > N (computed CNT_W+1 bits, no wrap) → `err_o`=1 and done pulse next cycle, no writes. Else → LOAD, `err_o` cleared.
- LOAD: `s_ready_o`=`cke_i`. Beat accepted when `s_valid_i & s_ready_o`. Each beat at current index k: waddr = k with low $clog2(WSTRB_W) bits cleared; wstrb = 1 << (k mod WSTRB_W); wdata = s_data_i zero-extended at bit (k mod WSTRB_W)*8, all other bits 0. Index increments, remaining decrements. Last beat → FLUSH.
- FLUSH: one cycle, `done_o`=1, → IDLE.
- `start_i` ignored in LOAD/FLUSH. No wrap-around past N-1 (excluded by range check).
- `wen_o` low in any cycle without a beat accepted in the previous cycle; `req_o` holds last value when `wen_o` low.
- `cke_i` low: state, counters, outputs hold; `s_ready_o`=0 (no acceptance).
- Reset mid-burst: immediate return to IDLE, outputs 0; writes already issued remain in the file.

## Timing
- Start sampled cycle 0 → `busy_o`=1, `s_ready_o`=1 from cycle 1.
- Beat accepted cycle t → `wen_o`=1 with its `req_o` in cycle t+1 (1-cycle registered latency). Back-to-back beats give back-to-back writes, full throughput.
- Last beat at t → FLUSH at t+1 (last write also at t+1), `done_o`=1 and `busy_o`=0 at t+2; register readable at t+2.
- Error/zero-length start at cycle 0 → `done_o` pulse cycle 1, `busy_o` stays 0.

## Structure
- Shared package: state encoding, `LANE_W`=$clog2(WSTRB_W), function for strobe/lane placement.
- Sub-module `iob_regfile_2p_lane_enc`: combinational index → {waddr, wstrb, wdata} encoder; FSM, counters and output registers in top.

## Test plan
- N=16, W=8, WDATA_W=32; base 5, len 3, data A1,A2,A3 continuous → writes {4,0010,0x0000A100}, {4,0100,0x00A20000}, {4,1000,0xA3000000} on consecutive cycles; done 2 cycles after last beat; file regs 5..7 = A1..A3.
- base 14, len 3 → `err_o`=1, done pulse next cycle, zero `wen_o`, `s_ready_o` never high; next valid start clears `err_o`.
- len 0 → done pulse next cycle, no writes, no error.
- base 0, len 16 with `s_valid_i` toggling every other cycle → 16 writes, one per accepted beat, final index 15 at waddr 12 wstrb 1000.
- `cke_i` low for 3 cycles mid-burst → no acceptance, outputs frozen, burst resumes unchanged.
- `rst_n_i` low during LOAD after 2 of 4 beats → next cycle IDLE, all outputs 0, no further writes, regs written earlier retained.

Source files
------------

// File: rtl/iob_regfile_2p_loader_pkg.sv
// Shared definitions for the register-file burst loader: FSM encoding and
// byte-lane placement helpers used by the index encoder.
package iob_regfile_2p_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int DEF_WSTRB_W = 4;
  localparam int LANE_W      = $clog2(DEF_WSTRB_W);

  // Places a byte on its lane only when that lane is selected by the index.
  function automatic logic [7:0] lane_byte(input logic [7:0] data, input logic hit);
    return hit ? data : 8'h00;
  endfunction

endpackage

// File: rtl/iob_regfile_2p_lane_enc.sv
// Combinational register index -> {word address, one-hot strobe, lane-placed data}
// encoder; each register owns exactly one byte lane of a file word.
module iob_regfile_2p_lane_enc
  import iob_regfile_2p_loader_pkg::*;
#(
  parameter int W       = 8,
  parameter int WDATA_W = 32,
  parameter int WADDR_W = 4,
  parameter int WSTRB_W = WDATA_W / 8
) (
  input  logic [WADDR_W-1:0] idx,
  input  logic [W-1:0]       data,
  output logic [WADDR_W-1:0] waddr,
  output logic [WSTRB_W-1:0] wstrb,
  output logic [WDATA_W-1:0] wdata
);

  localparam int LW = $clog2(WSTRB_W);

  logic [LW-1:0] lane;
  logic [7:0]    data_byte;

  assign lane      = idx[LW-1:0];
  assign data_byte = 8'(data);
  assign waddr     = {idx[WADDR_W-1:LW], {LW{1'b0}}};

  generate
    for (genvar gi = 0; gi < WSTRB_W; gi++) begin : g_lane
      logic hit;
      assign hit                = (lane == LW'(gi));
      assign wstrb[gi]          = hit;
      assign wdata[gi*8 +: 8]   = lane_byte(data_byte, hit);
    end
  endgenerate

endmodule

// File: rtl/iob_regfile_2p_loader.sv
// Burst write initiator: turns a start command plus a valid/ready value stream
// into single-register write requests on the register file's write port.
module iob_regfile_2p_loader
  import iob_regfile_2p_loader_pkg::*;
#(
  parameter int N       = 16,
  parameter int W       = 8,
  parameter int WDATA_W = 32,
  parameter int WADDR_W = 4,
  parameter int WSTRB_W = WDATA_W / 8,
  parameter int CNT_W   = $clog2(N) + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               cke_i,
  input  logic                               start_i,
  input  logic [WADDR_W-1:0]                 base_i,
  input  logic [CNT_W-1:0]                   len_i,
  input  logic                               s_valid_i,
  input  logic [W-1:0]                       s_data_i,
  output logic                               s_ready_o,
  output logic                               wen_o,
  output logic [WADDR_W+WSTRB_W+WDATA_W-1:0] req_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o
);

  // Range sum is wide enough that base+len never wraps before the compare.
  localparam int SUM_W = ((WADDR_W > CNT_W) ? WADDR_W : CNT_W) + 1;

  state_t                             state_reg;
  logic [WADDR_W-1:0]                 idx_reg;
  logic [CNT_W-1:0]                   rem_reg;
  logic                               wen_reg;
  logic [WADDR_W+WSTRB_W+WDATA_W-1:0] req_reg;
  logic                               busy_reg;
  logic                               done_reg;
  logic                               err_reg;

  logic [SUM_W-1:0]   range_sum;
  logic               beat;
  logic [WADDR_W-1:0] enc_waddr;
  logic [WSTRB_W-1:0] enc_wstrb;
  logic [WDATA_W-1:0] enc_wdata;

  assign range_sum = SUM_W'(base_i) + SUM_W'(len_i);
  assign s_ready_o = (state_reg == ST_LOAD) && cke_i;
  assign beat      = s_valid_i && s_ready_o;

  iob_regfile_2p_lane_enc #(
    .W       (W),
    .WDATA_W (WDATA_W),
    .WADDR_W (WADDR_W),
    .WSTRB_W (WSTRB_W)
  ) u_lane_enc (
    .idx   (idx_reg),
    .data  (s_data_i),
    .waddr (enc_waddr),
    .wstrb (enc_wstrb),
    .wdata (enc_wdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      rem_reg   <= '0;
      wen_reg   <= 1'b0;
      req_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (cke_i) begin
      wen_reg  <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            idx_reg <= base_i;
            rem_reg <= len_i;
            if (len_i == '0) begin
              done_reg <= 1'b1;
              err_reg  <= 1'b0;
            end else if (range_sum > SUM_W'(N)) begin
              done_reg <= 1'b1;
              err_reg  <= 1'b1;
            end else begin
              state_reg <= ST_LOAD;
              busy_reg  <= 1'b1;
              err_reg   <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (beat) begin
            wen_reg <= 1'b1;
            req_reg <= {enc_waddr, enc_wstrb, enc_wdata};
            idx_reg <= idx_reg + 1'b1;
            rem_reg <= rem_reg - 1'b1;
            if (rem_reg == CNT_W'(1)) state_reg <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign wen_o  = wen_reg;
  assign req_o  = req_reg;
  assign busy_o = busy_reg;
  assign done_o = done_reg;
  assign err_o  = err_reg;

endmodule

// File: tb/tb_iob_regfile_2p_loader.sv
// Directed bench for the burst loader, with a small byte-lane register file
// model fed from the write port.
module tb_iob_regfile_2p_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cke;
  logic        start;
  logic [3:0]  base;
  logic [4:0]  len;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        wen;
  logic [39:0] req;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  int wr_mark  = 0;
  logic [7:0] file_regs [16];

  always #5 clk = ~clk;

  iob_regfile_2p_loader dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .cke_i     (cke),
    .start_i   (start),
    .base_i    (base),
    .len_i     (len),
    .s_valid_i (s_valid),
    .s_data_i  (s_data),
    .s_ready_o (s_ready),
    .wen_o     (wen),
    .req_o     (req),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  // Register file model: one byte lane per register.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      wr_count++;
      for (int l = 0; l < 4; l++)
        if (req[32+l]) file_regs[req[39:36] + 4'(l)] = req[l*8 +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) file_regs[r] = 8'h00;
    rst_n = 1'b0; cke = 1'b1; start = 1'b0; base = '0; len = '0;
    s_valid = 1'b0; s_data = '0;
    tick(); tick();
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_flags", 64'({busy, done, err, s_ready}), 64'd0);
    rst_n = 1'b1;
    tick();

    // base 5, len 3, continuous stream
    start = 1'b1; base = 4'd5; len = 5'd3;
    tick();
    start = 1'b0;
    chk("b1_busy_ready", 64'({busy, s_ready, wen}), 64'b110);
    s_valid = 1'b1; s_data = 8'hA1;
    tick();
    chk("b1_w0", 64'({wen, req}), {23'd0, 1'b1, 4'd4, 4'b0010, 32'h0000A100});
    s_data = 8'hA2;
    tick();
    chk("b1_w1", 64'({wen, req}), {23'd0, 1'b1, 4'd4, 4'b0100, 32'h00A20000});
    s_data = 8'hA3;
    tick();
    chk("b1_w2", 64'({wen, req}), {23'd0, 1'b1, 4'd4, 4'b1000, 32'hA3000000});
    s_valid = 1'b0;
    tick();
    chk("b1_done", 64'({done, busy, wen}), 64'b100);
    tick();
    chk("b1_done_pulse", 64'(done), 64'd0);
    chk("b1_file", 64'({file_regs[5], file_regs[6], file_regs[7]}), 64'hA1A2A3);

    // out-of-range start
    wr_mark = wr_count;
    start = 1'b1; base = 4'd14; len = 5'd3;
    tick();
    start = 1'b0;
    chk("err_set", 64'({err, done, busy, s_ready}), 64'b1100);
    s_valid = 1'b1; s_data = 8'hEE;
    tick();
    chk("err_sticky", 64'({err, done, busy, s_ready, wen}), 64'b10000);
    tick();
    s_valid = 1'b0;
    chk("err_no_writes", 64'(wr_count - wr_mark), 64'd0);

    // base 0, len 16, valid every other cycle; also clears err
    wr_mark = wr_count;
    start = 1'b1; base = 4'd0; len = 5'd16;
    tick();
    start = 1'b0;
    chk("full_err_clr", 64'({err, busy}), 64'b01);
    for (int i = 0; i < 16; i++) begin
      logic [39:0] exp_req;
      exp_req = {4'(i & 12), 4'(1 << (i % 4)), 32'(32'(8'h10 + i) << (8 * (i % 4)))};
      s_valid = 1'b1; s_data = 8'(8'h10 + i);
      tick();
      chk($sformatf("full_w%0d", i), 64'({wen, req}), 64'({1'b1, exp_req}));
      s_valid = 1'b0;
      tick();
      chk($sformatf("full_gap%0d", i), 64'({wen, done}), (i == 15) ? 64'b01 : 64'b00);
    end
    chk("full_last_req", 64'(req), 64'({4'd12, 4'b1000, 32'h1F000000}));
    chk("full_count", 64'(wr_count - wr_mark), 64'd16);
    chk("full_file", 64'({file_regs[0], file_regs[9], file_regs[15]}), 64'h10191F);

    // zero length
    wr_mark = wr_count;
    start = 1'b1; base = 4'd3; len = 5'd0;
    tick();
    start = 1'b0;
    chk("len0_done", 64'({done, err, busy, s_ready}), 64'b1000);
    tick();
    chk("len0_no_writes", 64'({done, 5'(wr_count - wr_mark)}), 64'd0);

    // clock-enable stall mid-burst
    start = 1'b1; base = 4'd8; len = 5'd4;
    tick();
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'h55;
    tick();
    chk("cke_w0", 64'({wen, req}), {23'd0, 1'b1, 4'd8, 4'b0001, 32'h00000055});
    s_valid = 1'b0;
    tick();
    cke = 1'b0; s_valid = 1'b1; s_data = 8'h66;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("cke_hold%0d", c), 64'({s_ready, wen, busy, done, req}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 4'b0001, 32'h00000055}));
    end
    cke = 1'b1;
    tick();
    chk("cke_w1", 64'({wen, req}), {23'd0, 1'b1, 4'd8, 4'b0010, 32'h00006600});
    s_data = 8'h77;
    tick();
    s_data = 8'h88;
    tick();
    chk("cke_w3", 64'({wen, req}), {23'd0, 1'b1, 4'd8, 4'b1000, 32'h88000000});
    s_valid = 1'b0;
    tick();
    chk("cke_done", 64'({done, busy}), 64'b10);
    chk("cke_file", 64'({file_regs[8], file_regs[9], file_regs[10], file_regs[11]}), 64'h55667788);

    // reset during LOAD after 2 of 4 beats
    wr_mark = wr_count;
    start = 1'b1; base = 4'd0; len = 5'd4;
    tick();
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'hC0;
    tick();
    s_data = 8'hC1;
    tick();
    chk("rst_mid_w1", 64'(wen), 64'd1);
    rst_n = 1'b0; s_data = 8'hC2;
    tick();
    chk("rst_mid_out", 64'({wen, busy, done, err, s_ready, req}), 64'd0);
    rst_n = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    chk("rst_mid_count", 64'(wr_count - wr_mark), 64'd2);
    chk("rst_mid_file", 64'({file_regs[0], file_regs[1], file_regs[2], file_regs[3]}), 64'hC0C11213);
    chk("rst_mid_idle", 64'({busy, s_ready, wen}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
